// File: rtl/phase_seq_pkg.sv
// Shared definitions for the phase sequencer.
//   state_t   : sequencer control states (IDLE, RUN, HALTED)
//   MODE_*    : execution mode encodings presented on the mode switches
//   map_mode  : folds the reserved mode 2'b11 onto continuous
package phase_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] MODE_CONT  = 2'b00;
  localparam logic [1:0] MODE_INSTR = 2'b01;
  localparam logic [1:0] MODE_PHASE = 2'b10;

  function automatic logic [1:0] map_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_CONT : m;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clock : system clock
//   reset : asynchronous active-low reset
//   din   : raw asynchronous level (exec button)
//   pulse : one-cycle pulse per rising edge of the synchronized level
module edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, so the chain really is three stages deep regardless of order.
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Only sync2 and prev feed the detector; sync1 may still be metastable.
  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/phase_sequencer.sv
// Run/stop phase sequencer: generates registered one-hot phase enables for
// the datapath, with continuous, instruction-step and phase-step modes,
// halt at instruction boundary, graceful stop and a retired-instruction count.
//   clock       : system clock, all state on rising edge
//   reset       : asynchronous active-low reset
//   exec        : raw asynchronous exec button/level
//   mode        : 00 continuous, 01 instruction-step, 10 phase-step, 11 as 00
//   halt        : halt request, only honoured in the last phase
//   phase       : current phase index
//   phase_en    : one-hot enable of the active phase, zero when not executing
//   running     : high in RUN
//   halted      : high in HALTED
//   instr_done  : high in the cycle the last phase is enabled
//   instr_count : retired instructions, wraps
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int PHASE_W    = $clog2(NUM_PHASES),
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec,
  input  logic [1:0]            mode,
  input  logic                  halt,
  output logic [PHASE_W-1:0]    phase,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic                  running,
  output logic                  halted,
  output logic                  instr_done,
  output logic [CNT_W-1:0]      instr_count
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  state_t                  state, state_n;
  logic [PHASE_W-1:0]      phase_n;
  logic [NUM_PHASES-1:0]   phase_en_n;
  logic [CNT_W-1:0]        count_n;
  logic                    stop_pending, stop_pending_n;
  logic [1:0]              mode_q, mode_q_n;
  logic [1:0]              mode_new;
  logic                    exec_pulse;
  logic                    active;
  logic                    last;
  logic                    step;

  edge_sync u_exec_sync (
    .clock (clock),
    .reset (reset),
    .din   (exec),
    .pulse (exec_pulse)
  );

  // A phase "executes" in the cycle its enable is high; it retires on the
  // edge that ends that cycle, which is where phase, count and exits update.
  assign active   = |phase_en;
  assign last     = active && (phase == LAST_PHASE);
  assign mode_new = map_mode(mode);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_n        = state;
    phase_n        = phase;
    count_n        = instr_count;
    stop_pending_n = stop_pending;
    mode_q_n       = mode_q;
    step           = 1'b0;
    phase_en_n     = '0;

    if (active) begin
      if (!last) begin
        phase_n = phase + PHASE_W'(1);
      end else begin
        phase_n = '0;
        count_n = instr_count + CNT_W'(1);
        if (halt) begin
          state_n        = HALTED;
          stop_pending_n = 1'b0;
        end else if (stop_pending || (mode_q == MODE_INSTR)) begin
          state_n        = IDLE;
          stop_pending_n = 1'b0;
        end
      end
    end

    if (exec_pulse) begin
      case (state)
        RUN: begin
          // A stop request only survives if we are still running afterwards.
          if (state_n == RUN) stop_pending_n = 1'b1;
        end
        IDLE, HALTED: begin
          // A phase-step enable in flight finishes before a new start.
          if (!active) begin
            mode_q_n = mode_new;
            if (mode_new == MODE_PHASE) begin
              state_n = IDLE;
              step    = 1'b1;
            end else begin
              state_n = RUN;
            end
          end
        end
        default: ;
      endcase
    end

    if ((state_n == RUN) || step) phase_en_n[phase_n] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      phase        <= '0;
      phase_en     <= '0;
      instr_done   <= 1'b0;
      instr_count  <= '0;
      stop_pending <= 1'b0;
      mode_q       <= MODE_CONT;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      phase_en     <= phase_en_n;
      instr_done   <= phase_en_n[NUM_PHASES-1];
      instr_count  <= count_n;
      stop_pending <= stop_pending_n;
      mode_q       <= mode_q_n;
    end
  end

  assign running = (state == RUN);
  assign halted  = (state == HALTED);

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer (NUM_PHASES=5, CNT_W=4).
module tb_phase_sequencer;
  import phase_seq_pkg::*;

  localparam int NP = 5;
  localparam int PW = 3;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          exec;
  logic [1:0]    mode;
  logic          halt;
  logic [PW-1:0] phase;
  logic [NP-1:0] phase_en;
  logic          running;
  logic          halted;
  logic          instr_done;
  logic [CW-1:0] instr_count;

  typedef struct packed {
    logic [PW-1:0] ph;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  phase_sequencer #(.NUM_PHASES(NP), .PHASE_W(PW), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .exec        (exec),
    .mode        (mode),
    .halt        (halt),
    .phase       (phase),
    .phase_en    (phase_en),
    .running     (running),
    .halted      (halted),
    .instr_done  (instr_done),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expect n consecutive enabled cycles starting at phase 'first'.
  task automatic push_phases(input int first, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.ph   = PW'((first + i) % NP);
      e.done = (((first + i) % NP) == NP - 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every cycle with an enable or instr_done consumes one entry.
  always @(negedge clock) begin
    exp_t          e;
    logic [NP-1:0] want;
    if (phase_en != '0 || instr_done) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_enable: got phase_en=%b instr_done=%b expected no activity",
                 phase_en, instr_done);
      end else begin
        e    = exp_q.pop_front();
        want = NP'(1) << e.ph;
        if (phase_en !== want || instr_done !== e.done || phase !== e.ph) begin
          n_err++;
          $display("FAIL enable_seq: got phase=%0d phase_en=%b done=%b expected phase=%0d phase_en=%b done=%b",
                   phase, phase_en, instr_done, e.ph, want, e.done);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    exec  = 1'b0;
    mode  = MODE_CONT;
    halt  = 1'b0;
    cyc(3);
    check("rst_phase",    phase, 0);
    check("rst_phase_en", phase_en, 0);
    check("rst_running",  running, 0);
    check("rst_halted",   halted, 0);
    check("rst_done",     instr_done, 0);
    check("rst_count",    instr_count, 0);
    reset = 1'b1;
    cyc(3);

    // Continuous run, then graceful stop requested during phase 2 of instr 4.
    push_phases(0, 20);
    exec = 1'b1;
    cyc(2);
    check("latency_edge2", phase_en, 0);
    cyc(1);
    check("latency_edge3", phase_en, 5'b00001);
    check("cont_running",  running, 1);
    cyc(2);
    exec = 1'b0;
    cyc(13);
    check("cont_count3", instr_count, 3);
    exec = 1'b1;
    cyc(4);
    exec = 1'b0;
    cyc(3);
    check("stop_running",  running, 0);
    check("stop_phase",    phase, 0);
    check("stop_phase_en", phase_en, 0);
    check("stop_count",    instr_count, 4);

    // Instruction-step: two presses, one instruction each.
    mode = MODE_INSTR;
    for (int k = 0; k < 2; k++) begin
      push_phases(0, 5);
      exec = 1'b1;
      cyc(3);
      exec = 1'b0;
      cyc(8);
      check("istep_running", running, 0);
    end
    check("istep_count", instr_count, 6);
    check("istep_phase", phase, 0);

    // Phase-step: seven presses, phases 0..4,0,1.
    mode = MODE_PHASE;
    push_phases(0, 7);
    for (int k = 0; k < 7; k++) begin
      exec = 1'b1;
      cyc(3);
      exec = 1'b0;
      cyc(3);
    end
    check("pstep_phase",   phase, 2);
    check("pstep_count",   instr_count, 7);
    check("pstep_running", running, 0);
    check("pstep_halted",  halted, 0);

    // Reset asserted during phase 3 of a continuous run started at phase 2.
    mode = MODE_CONT;
    push_phases(2, 2);
    exec = 1'b1;
    cyc(3);
    exec = 1'b0;
    cyc(1);
    #5;
    reset = 1'b0;
    #1;
    check("midrst_phase",    phase, 0);
    check("midrst_phase_en", phase_en, 0);
    check("midrst_running",  running, 0);
    check("midrst_done",     instr_done, 0);
    check("midrst_count",    instr_count, 0);
    #2;
    reset = 1'b1;
    cyc(2);

    // Halt: pulse in phase 2 ignored, held phase 1..4 of instr 2 halts.
    push_phases(0, 10);
    exec = 1'b1;
    cyc(3);
    exec = 1'b0;
    cyc(2);
    halt = 1'b1;
    cyc(1);
    halt = 1'b0;
    cyc(3);
    halt = 1'b1;
    cyc(5);
    halt = 1'b0;
    check("halt_halted",   halted, 1);
    check("halt_running",  running, 0);
    check("halt_phase",    phase, 0);
    check("halt_phase_en", phase_en, 0);
    check("halt_count",    instr_count, 2);
    cyc(5);
    check("halt_stays", halted, 1);

    // Resume from HALTED in continuous mode, stop requested in phase 3.
    push_phases(0, 5);
    exec = 1'b1;
    cyc(3);
    exec = 1'b0;
    cyc(1);
    exec = 1'b1;
    cyc(2);
    exec = 1'b0;
    cyc(5);
    check("resume_running", running, 0);
    check("resume_halted",  halted, 0);
    check("resume_count",   instr_count, 3);

    // Counter wrap: 13 more instructions take the 4-bit count 3 -> 0.
    push_phases(0, 65);
    exec = 1'b1;
    cyc(5);
    exec = 1'b0;
    cyc(58);
    check("wrap_count15", instr_count, 15);
    exec = 1'b1;
    cyc(4);
    exec = 1'b0;
    cyc(3);
    check("wrap_count0",  instr_count, 0);
    check("wrap_running", running, 0);

    // Exec held high for 50 cycles starts exactly one instruction.
    mode = MODE_INSTR;
    push_phases(0, 5);
    exec = 1'b1;
    cyc(50);
    exec = 1'b0;
    cyc(5);
    check("hold_count",   instr_count, 1);
    check("hold_running", running, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Parametrised successor to the fixed 5-phase run/stop controller.
- Owns its own phase counter and generates registered one-hot phase enables. No gated clocks.
- Supports three execution modes (continuous, instruction-step, phase-step), halt at instruction boundary, graceful stop and a retired-instruction counter.
- Sits between the board controls (exec button, mode switches) and the datapath phase logic.

Parameters:
- NUM_PHASES, 5, phases per instruction (>=2).
- PHASE_W, $clog2(NUM_PHASES), width of the phase index.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- exec  in  1  raw asynchronous exec button/level
- mode  in  2  00 continuous, 01 instruction-step, 10 phase-step, 11 reserved (treated as 00)
- halt  in  1  halt request from datapath, sampled only in the last phase
- phase  out  PHASE_W  current phase index
- phase_en  out  NUM_PHASES  one-hot enable for the active phase, all-zero when not executing
- running  out  1  high in RUN state
- halted  out  1  high in HALTED state
- instr_done  out  1  one-cycle pulse in the cycle the last phase is enabled
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, phase=0, phase_en=0, running=0, halted=0, instr_done=0, instr_count=0.
  - Synchronizer and edge flops = 0, stop_pending=0, mode_q=00.
  - Reset mid-instruction aborts immediately; no instr_done.
- Exec path:
  - 2-flop synchronizer, then rising-edge detect gives exec_pulse (1 cycle).
  - Level hold yields exactly one pulse.
  - First phase_en bit goes high after the 3rd rising clock edge following exec going high (setup met).
- mode is latched into mode_q only on exec_pulse taken from IDLE or HALTED.
- States: IDLE, RUN, HALTED.
- IDLE:
  - exec_pulse with mode_q=continuous or instruction-step: go to RUN, phase_en=onehot(phase).
  - exec_pulse with phase-step: stay IDLE and issue exactly one phase_en cycle for the current phase, then advance phase.
- RUN:
  - phase_en=onehot(phase) every cycle.
  - phase increments each cycle and wraps NUM_PHASES-1 -> 0.
- Last phase (phase==NUM_PHASES-1 with phase_en active, any mode):
  - instr_done=1; instr_count+1 on the same edge.
  - Exit priority at that edge:
    - halt=1: go to HALTED, phase=0.
    - else stop_pending=1 or mode_q=instruction-step: go to IDLE, phase=0, clear stop_pending.
    - else continue in RUN.
- exec_pulse in RUN sets stop_pending. It never stops mid-instruction.
- halt outside the last phase is ignored (no latching).
- HALTED:
  - phase_en=0; only exec_pulse exits.
  - Exit to RUN if the new mode_q is continuous or instruction-step; to IDLE plus one phase step if phase-step.
- Phase-step with halt=1 on the last phase: HALTED, same as the other modes.
- Outputs phase, phase_en, running, halted and instr_done are registered; no combinational path from inputs.
- phase holds its value while IDLE or HALTED.

Decomposition:
- Package phase_seq_pkg:
  - state enum (IDLE, RUN, HALTED).
  - mode constants MODE_CONT=2'b00, MODE_INSTR=2'b01, MODE_PHASE=2'b10.
- One sub-module, edge_sync: 2-flop synchronizer plus rising-edge pulse, async active-low reset.

Test Plan:
- Continuous run, NUM_PHASES=5: exec high at t0 -> phase_en 00001 from the 3rd edge, then 00010, 00100, 01000, 10000, repeating. instr_done pulses every 5 cycles. instr_count=3 after 15 enabled cycles.
- Graceful stop: exec pulse while phase=2 -> phases 3,4 complete, instr_done pulse, then IDLE with phase=0, phase_en=0, running=0.
- Instruction-step: mode=01, exec pulse -> exactly 5 phase_en cycles, one instr_done, back to IDLE. A second pulse repeats this; instr_count=2.
- Phase-step: mode=10, 7 exec pulses -> 7 single-cycle phase_en pulses on phases 0,1,2,3,4,0,1. instr_done once; phase=2 at end.
- Halt: halt=1 held from phase 1 and still high in phase 4 -> halted=1, phase=0, no further phase_en. halt pulsed only in phase 2 -> ignored. Exec pulse from HALTED with mode=00 -> RUN resumes at phase 0.
- Reset and wrap:
  - reset=0 asserted during phase 3 -> all outputs 0 immediately, no instr_done.
  - CNT_W=4: 16 instructions -> instr_count wraps to 0.
  - Exec held high for 50 cycles -> single start only.
